// File: rtl/bram_tdp_model.sv
// rtl/bram_tdp_model.sv - true-dual-port block-RAM model with lane write enables
// Zeroes every entry after reset with a clear sequencer; selectable read latency and read-during-write mode.
module bram_tdp_model #(
  parameter int DATA_SIZE    = 149,
  parameter int ADDR_SIZE    = 8,
  parameter int WE_WIDTH     = 1,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  output logic                 init_busy,
  input  logic                 ena,
  input  logic [WE_WIDTH-1:0]  wea,
  input  logic [ADDR_SIZE-1:0] addra,
  input  logic [DATA_SIZE-1:0] dina,
  output logic [DATA_SIZE-1:0] douta,
  input  logic                 enb,
  input  logic [WE_WIDTH-1:0]  web,
  input  logic [ADDR_SIZE-1:0] addrb,
  input  logic [DATA_SIZE-1:0] dinb,
  output logic [DATA_SIZE-1:0] doutb
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam int LW    = DATA_SIZE / WE_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] rd_a, rd_b, merged_a, merged_b, wdata_a;
  logic [DATA_SIZE-1:0] s1a_q, s1b_q;
  logic                 wr_a, wr_b, ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + ADDR_SIZE'(1);
      if (&cnt_q) state_d = READY;
    end
  end

  assign init_busy = (state_q == CLEAR);
  assign ready     = (state_q == READY);
  assign wr_a      = ena && (|wea);
  assign wr_b      = enb && (|web);

  // On a same-address double write, port A's word also carries the lanes only B enabled.
  always_comb begin
    rd_a     = mem[addra];
    rd_b     = mem[addrb];
    merged_a = rd_a;
    merged_b = rd_b;
    for (int i = 0; i < WE_WIDTH; i++) begin
      if (wea[i]) merged_a[i*LW +: LW] = dina[i*LW +: LW];
      if (web[i]) merged_b[i*LW +: LW] = dinb[i*LW +: LW];
    end
    wdata_a = merged_a;
    if (wr_b && (addra == addrb)) begin
      for (int i = 0; i < WE_WIDTH; i++) begin
        if (!wea[i] && web[i]) wdata_a[i*LW +: LW] = dinb[i*LW +: LW];
      end
    end
  end

  // Port A is written last so it wins any same-address collision.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_b) mem[addrb] <= merged_b;
      if (wr_a) mem[addra] <= wdata_a;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1a_q <= '0;
      s1b_q <= '0;
    end else if (ready) begin
      if (ena) begin
        if (!(|wea))             s1a_q <= rd_a;
        else if (WRITE_MODE == 0) s1a_q <= merged_a;
        else if (WRITE_MODE == 1) s1a_q <= rd_a;
      end
      if (enb) begin
        if (!(|web))             s1b_q <= rd_b;
        else if (WRITE_MODE == 0) s1b_q <= merged_b;
        else if (WRITE_MODE == 1) s1b_q <= rd_b;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_SIZE-1:0] s2a_q, s2b_q;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          s2a_q <= '0;
          s2b_q <= '0;
        end else begin
          s2a_q <= s1a_q;
          s2b_q <= s1b_q;
        end
      end
      assign douta = s2a_q;
      assign doutb = s2b_q;
    end else begin : g_lat1
      assign douta = s1a_q;
      assign doutb = s1b_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_tdp_model.sv
// tb/tb_bram_tdp_model.sv - scoreboard bench for bram_tdp_model
// Instances: 0..2 are latency 1 with write modes 0..2, 3 is latency 2 write-first.
module tb_bram_tdp_model;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ena, enb;
  logic [3:0]  wea, web, addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] dout_w [8];
  logic        busy_w [4];

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t sb [8][$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    bram_tdp_model #(
      .DATA_SIZE(32), .ADDR_SIZE(4), .WE_WIDTH(4),
      .READ_LATENCY(g == 3 ? 2 : 1), .WRITE_MODE(g == 3 ? 0 : g)
    ) u_dut (
      .clk(clk), .resetn(resetn), .init_busy(busy_w[g]),
      .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout_w[2*g]),
      .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout_w[2*g+1])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      while (sb[k].size() != 0 && sb[k][0].due <= edge_cnt) begin
        e = sb[k].pop_front();
        check($sformatf("sb_i%0d_%s_e%0d", k / 2, (k % 2) ? "b" : "a", e.due), dout_w[k], e.val);
      end
    end
  end

  task automatic step(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    @(negedge clk);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic exp4(input int p, input logic [31:0] v0, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] v3);
    exp_t e;
    logic [31:0] v [4];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    for (int g = 0; g < 4; g++) begin
      e.due = edge_cnt + 1 + (g == 3 ? 1 : 0);
      e.val = v[g];
      sb[2*g+p].push_back(e);
    end
  endtask

  task automatic check_zero_outs(input string nm);
    for (int k = 0; k < 8; k++) check($sformatf("%s_dout%0d", nm, k), dout_w[k], 32'h0);
  endtask

  task automatic check_busy(input string nm, input logic req);
    for (int g = 0; g < 4; g++) check($sformatf("%s_busy%0d", nm, g), {31'b0, busy_w[g]}, {31'b0, req});
  endtask

  task automatic wait_clear(input string nm);
    int n = 0;
    while (n < 64) begin
      @(posedge clk);
      n++;
      #1;
      if (!busy_w[0]) break;
    end
    check(nm, n, 32'd16);
    check_busy({nm, "_end"}, 1'b0);
  endtask

  initial begin
    int w;
    resetn = 1'b0;
    ena = 0; wea = 0; addra = 0; dina = 0;
    enb = 0; web = 0; addrb = 0; dinb = 0;
    #1;
    check_busy("por", 1'b1);
    check_zero_outs("por");
    @(negedge clk); resetn = 1'b1;
    wait_clear("clear1_len");

    // Fill with garbage, read two entries so outputs are nonzero before the next reset.
    for (int i = 0; i < 16; i++) step(1'b1, 4'hF, 4'(i), 32'hDEAD0100 + 32'(i), 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b1, 4'h0, 4'd4, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
    exp4(0, 32'hDEAD0104, 32'hDEAD0104, 32'hDEAD0104, 32'hDEAD0104);
    exp4(1, 32'hDEAD0109, 32'hDEAD0109, 32'hDEAD0109, 32'hDEAD0109);
    repeat (3) idle();

    @(negedge clk); #2 resetn = 1'b0;
    #1;
    check_busy("async", 1'b1);
    check_zero_outs("async");
    @(negedge clk);
    ena = 1; wea = 4'hF; addra = 4'd0; dina = 32'hCAFEF00D;
    enb = 1; web = 4'hF; addrb = 4'd1; dinb = 32'hBADDCAFE;
    resetn = 1'b1;
    wait_clear("clear2_len");
    check_zero_outs("busy_drop");
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(15 - i), 32'h0);
      exp4(0, 32'h0, 32'h0, 32'h0, 32'h0);
      exp4(1, 32'h0, 32'h0, 32'h0, 32'h0);
    end

    step(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0, 4'h0, 32'h0);
    exp4(0, 32'hAABBCCDD, 32'h0, 32'h0, 32'hAABBCCDD);
    step(1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'h0, 4'h0, 32'h0);
    exp4(0, 32'hAA22CC44, 32'hAABBCCDD, 32'h0, 32'hAA22CC44);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    exp4(1, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);

    step(1'b1, 4'hF, 4'd7, 32'h33, 1'b0, 4'h0, 4'h0, 32'h0);
    exp4(0, 32'h33, 32'h0, 32'h0, 32'h33);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hF, 4'd8, 32'h77);
    step(1'b1, 4'h0, 4'd8, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    exp4(0, 32'h77, 32'h77, 32'h77, 32'h77);
    step(1'b1, 4'hF, 4'd7, 32'h55, 1'b0, 4'h0, 4'h0, 32'h0);
    exp4(0, 32'h55, 32'h33, 32'h77, 32'h55);
    step(1'b1, 4'h0, 4'd7, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    exp4(0, 32'h55, 32'h55, 32'h55, 32'h55);

    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hF, 4'd1, 32'd10);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hF, 4'd2, 32'd20);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'hF, 4'd3, 32'd30);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd1, 32'h0);
    exp4(1, 32'd10, 32'd10, 32'd10, 32'd10);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd2, 32'h0);
    exp4(1, 32'd20, 32'd20, 32'd20, 32'd20);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
    exp4(1, 32'd30, 32'd30, 32'd30, 32'd30);

    step(1'b1, 4'hF, 4'd5, 32'hF0, 1'b1, 4'hF, 4'd5, 32'h0F);
    step(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    exp4(0, 32'hF0, 32'hF0, 32'hF0, 32'hF0);
    step(1'b1, 4'h1, 4'd9, 32'h000000AA, 1'b1, 4'h3, 4'd9, 32'h0000BBCC);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd9, 32'h0);
    exp4(1, 32'h0000BBAA, 32'h0000BBAA, 32'h0000BBAA, 32'h0000BBAA);
    step(1'b1, 4'hF, 4'd6, 32'h44, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b1, 4'hF, 4'd6, 32'h99, 1'b1, 4'h0, 4'd6, 32'h0);
    exp4(1, 32'h44, 32'h44, 32'h44, 32'h44);
    step(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd6, 32'h0);
    exp4(1, 32'h99, 32'h99, 32'h99, 32'h99);
    step(1'b1, 4'hF, 4'd12, 32'hCAFE, 1'b0, 4'h0, 4'h0, 32'h0);
    repeat (4) idle();

    @(negedge clk); resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    repeat (7) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check_busy("midclr", 1'b1);
    check_zero_outs("midclr");
    @(negedge clk); resetn = 1'b1;
    wait_clear("clear3_len");
    step(1'b1, 4'h0, 4'd12, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    exp4(0, 32'h0, 32'h0, 32'h0, 32'h0);
    exp4(1, 32'h0, 32'h0, 32'h0, 32'h0);
    idle();

    w = 0;
    while (w < 20) begin
      int pending = 0;
      for (int k = 0; k < 8; k++) pending += sb[k].size();
      if (pending == 0) break;
      @(negedge clk);
      w++;
    end
    for (int k = 0; k < 8; k++) begin
      if (sb[k].size() != 0) check($sformatf("sb_drain%0d", k), sb[k].size(), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
